vga_timing_gen: RTL and testbench

Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock. It sits directly upstream of the sprite/background pixel stages, which take DrawX, DrawY and blank and return registered RGB one clock later. It also produces hs/vs delayed to line up with that RGB, a frame-end strobe and a frame counter for animation logic.

---
 rtl/vga_timing_gen_if.sv | 13 +
 rtl/vga_timing_gen.sv | 94 +++++++++
 tb/tb_vga_timing_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster outputs of the VGA timing generator, shared with the pixel stages.
interface vga_timing_gen_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        frame_end;
    logic [15:0] frame_count;

    modport master (output DrawX, DrawY, blank, hs, vs, frame_end, frame_count);
    modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_end, frame_count);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters, blank decode, sync pulses
// delayed to line up with the registered RGB of the downstream pixel stages.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [15:0] frame_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        hs_raw;
    logic        vs_raw;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
        end else begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
            if (h_wrap && v_wrap)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign hs_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));

    assign vga.DrawX       = h_cnt;
    assign vga.DrawY       = v_cnt;
    assign vga.blank       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign vga.frame_end   = h_wrap && v_wrap;
    assign vga.frame_count = frame_cnt;

    // Sync pipeline depth matches the RGB latency of the pixel stages.
    generate
        if (SYNC_DELAY == 0) begin : g_sync_comb
            assign vga.hs = hs_raw;
            assign vga.vs = vs_raw;
        end else begin : g_sync_pipe
            logic [SYNC_DELAY-1:0] hs_pipe;
            logic [SYNC_DELAY-1:0] vs_pipe;

            always_ff @(posedge vga_clk or posedge reset) begin
                if (reset) begin
                    hs_pipe <= '1;
                    vs_pipe <= '1;
                end else begin
                    hs_pipe[0] <= hs_raw;
                    vs_pipe[0] <= vs_raw;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        hs_pipe[i] <= hs_pipe[i-1];
                        vs_pipe[i] <= vs_pipe[i-1];
                    end
                end
            end

            assign vga.hs = hs_pipe[SYNC_DELAY-1];
            assign vga.vs = vs_pipe[SYNC_DELAY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instances for line timing and reset,
// a shrunken raster for frame-level behaviour and frame_count rollover.
module tb_vga_timing_gen;
    logic vga_clk = 1'b0;
    logic rst_a, rst_b, rst_c;

    always #20 vga_clk = ~vga_clk;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if ifb ();
    vga_timing_gen_if ifc ();

    vga_timing_gen #(.SYNC_DELAY(1)) dut_a (.vga_clk(vga_clk), .reset(rst_a), .vga(ifa));

    // Small raster: H_TOTAL = 16 (hs low x 10..12), V_TOTAL = 11 (vs low y 7..8), frame = 176.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_DELAY(1)
    ) dut_b (.vga_clk(vga_clk), .reset(rst_b), .vga(ifb));

    vga_timing_gen #(.SYNC_DELAY(0)) dut_c (.vga_clk(vga_clk), .reset(rst_c), .vga(ifc));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    // Expected small-raster word at sample m after reset release, derived from elapsed clocks.
    function automatic logic [31:0] b_word(input int m);
        int   x, y, px, py;
        logic hs_e, vs_e;
        x = m % 16;
        y = (m / 16) % 11;
        if (m == 0) begin
            hs_e = 1'b1;
            vs_e = 1'b1;
        end else begin
            px   = (m - 1) % 16;
            py   = ((m - 1) / 16) % 11;
            hs_e = !(px >= 10 && px <= 12);
            vs_e = !(py >= 7 && py <= 8);
        end
        return {10'(x), 10'(y), 1'(x < 8 && y < 6), hs_e, vs_e,
                1'(x == 15 && y == 10), 8'(m / 176)};
    endfunction

    function automatic logic [31:0] b_obs();
        return {ifb.DrawX, ifb.DrawY, ifb.blank, ifb.hs, ifb.vs,
                ifb.frame_end, ifb.frame_count[7:0]};
    endfunction

    initial begin
        int blank_cnt, blank_ok, hs_low, hs_first, hs_last, hsc_low, hsc_first;
        int vs_low, vs_first, fe_cnt;
        logic [19:0] pos_799;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        tick(2);

        // Reset state while held.
        push("rst_drawx", 32'd0);       check(32'(ifa.DrawX));
        push("rst_drawy", 32'd0);       check(32'(ifa.DrawY));
        push("rst_blank", 32'd1);       check(32'(ifa.blank));
        push("rst_hs", 32'd1);          check(32'(ifa.hs));
        push("rst_vs", 32'd1);          check(32'(ifa.vs));
        push("rst_frame_end", 32'd0);   check(32'(ifa.frame_end));
        push("rst_frame_count", 32'd0); check(32'(ifa.frame_count));

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Line 0 and the wrap into line 1 on the full-size instances.
        blank_cnt = 0; blank_ok = 0; hs_low = 0; hs_first = -1; hs_last = -1;
        hsc_low = 0; hsc_first = -1; pos_799 = '0;
        for (int n = 0; n < 800; n++) begin
            if (ifa.blank) blank_cnt++;
            if (ifa.blank && ifa.DrawX < 640 && ifa.DrawY == 0) blank_ok++;
            if (!ifa.hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(ifa.DrawX);
                hs_last = int'(ifa.DrawX);
            end
            if (!ifc.hs) begin
                hsc_low++;
                if (hsc_first < 0) hsc_first = int'(ifc.DrawX);
            end
            if (n == 799) pos_799 = {ifa.DrawX, ifa.DrawY};
            tick(1);
        end
        push("line_blank_count", 32'd640);  check(32'(blank_cnt));
        push("line_blank_region", 32'd640); check(32'(blank_ok));
        push("hs_low_clocks", 32'd96);      check(32'(hs_low));
        push("hs_first_low_x", 32'd657);    check(32'(hs_first));
        push("hs_last_low_x", 32'd752);     check(32'(hs_last));
        push("hs0_low_clocks", 32'd96);     check(32'(hsc_low));
        push("hs0_first_low_x", 32'd656);   check(32'(hsc_first));
        push("pos_before_wrap", {12'd0, 10'd799, 10'd0}); check({12'd0, pos_799});
        push("pos_after_wrap", {12'd0, 10'd0, 10'd1});    check({12'd0, ifa.DrawX, ifa.DrawY});

        // Mid-line reset during hs low, with no clock edge.
        tick(1500);
        push("pre_rst_pos", {12'd0, 10'd700, 10'd2}); check({12'd0, ifa.DrawX, ifa.DrawY});
        push("pre_rst_hs", 32'd0);                    check(32'(ifa.hs));
        #5 rst_a = 1'b1;
        #1;
        push("async_rst_drawx", 32'd0);       check(32'(ifa.DrawX));
        push("async_rst_drawy", 32'd0);       check(32'(ifa.DrawY));
        push("async_rst_hs", 32'd1);          check(32'(ifa.hs));
        push("async_rst_vs", 32'd1);          check(32'(ifa.vs));
        push("async_rst_frame_count", 32'd0); check(32'(ifa.frame_count));
        tick(1);
        push("rst_held_drawx", 32'd0); check(32'(ifa.DrawX));
        rst_a = 1'b0;
        push("rel_drawx", 32'd0); check(32'(ifa.DrawX));
        tick(1);
        push("first_edge_drawx", 32'd1); check(32'(ifa.DrawX));

        // Small raster: every clock across three frames against the elapsed-clock model.
        rst_b = 1'b1;
        tick(1);
        rst_b = 1'b0;
        vs_low = 0; vs_first = -1; fe_cnt = 0;
        for (int m = 0; m <= 530; m++) begin
            push("raster_b", b_word(m));
            check(b_obs());
            if (m < 176 && !ifb.vs) begin
                vs_low++;
                if (vs_first < 0) vs_first = m;
            end
            if (m < 528 && ifb.frame_end) fe_cnt++;
            if (m == 528) begin
                push("three_frames_count", 32'd3); check(32'(ifb.frame_count));
            end
            if (m < 530) tick(1);
        end
        push("vs_low_clocks", 32'd32);      check(32'(vs_low));
        push("vs_first_low_clk", 32'd113);  check(32'(vs_first));
        push("frame_end_pulses", 32'd3);    check(32'(fe_cnt));

        // frame_count rollover; counters must be undisturbed.
        force dut_b.frame_cnt = 16'hFFFF;
        #1 release dut_b.frame_cnt;
        push("forced_count", 32'h0000FFFF);        check(32'(ifb.frame_count));
        push("forced_pos", {12'd0, 10'd2, 10'd0}); check({12'd0, ifb.DrawX, ifb.DrawY});
        tick(173);
        push("pre_roll_pos", {12'd0, 10'd15, 10'd10}); check({12'd0, ifb.DrawX, ifb.DrawY});
        push("pre_roll_frame_end", 32'd1);            check(32'(ifb.frame_end));
        push("pre_roll_count", 32'h0000FFFF);         check(32'(ifb.frame_count));
        tick(1);
        push("roll_count", 32'd0);               check(32'(ifb.frame_count));
        push("roll_pos", 32'd0);                 check({12'd0, ifb.DrawX, ifb.DrawY});
        push("roll_frame_end", 32'd0);           check(32'(ifb.frame_end));

        if (sb.size() != 0) begin
            bad++;
            total++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
